bus_ctrl: RTL and testbench

BUS_CTRL -- requirements
Module: bus_ctrl

---
 rtl/bus_ctrl_pkg.sv | 9 +
 rtl/bus_region_match.sv | 25 ++
 rtl/bus_ctrl.sv | 104 ++++++++++
 tb/tb_bus_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: FSM states, wait-counter width and error read fill shared by bus_ctrl
package bus_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
   localparam int CNT_W = 4;
   localparam logic ERR_FILL = 1'b1;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bus_region_match.sv
// bus_region_match: N-way masked address compare with lowest-index priority
module bus_region_match
   import bus_ctrl_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int N_SLAVES = 2,
   parameter int IDX_W = idx_w(N_SLAVES),
   parameter logic [N_SLAVES*ADDR_W-1:0] REGION_BASE = {16'hF800, 16'h0000},
   parameter logic [N_SLAVES*ADDR_W-1:0] REGION_MASK = {16'hF800, 16'h8000}
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_hit,
   output logic [IDX_W-1:0]  o_idx
);
   // scanning high to low lets the lowest matching region overwrite the rest
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int k = N_SLAVES - 1; k >= 0; k--)
         if ((i_addr & REGION_MASK[k*ADDR_W +: ADDR_W]) == REGION_BASE[k*ADDR_W +: ADDR_W]) begin
            o_hit = 1'b1;
            o_idx = IDX_W'(k);
         end
   end
endmodule

// File: rtl/bus_ctrl.sv
// bus_ctrl: CPU-to-slave bus controller with region decode, wait states and error response
module bus_ctrl
   import bus_ctrl_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int N_SLAVES = 2,
   parameter logic [N_SLAVES*ADDR_W-1:0] REGION_BASE = {16'hF800, 16'h0000},
   parameter logic [N_SLAVES*ADDR_W-1:0] REGION_MASK = {16'hF800, 16'h8000},
   parameter logic [N_SLAVES*CNT_W-1:0]  REGION_WAIT = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_W-1:0]          cpu_address,
   input  logic                       cpu_read,
   input  logic                       cpu_write,
   input  logic [DATA_W-1:0]          cpu_wdata,
   output logic [DATA_W-1:0]          cpu_rdata,
   output logic                       cpu_ready,
   output logic                       bus_error,
   output logic [ADDR_W-1:0]          slv_address,
   output logic [DATA_W-1:0]          slv_wdata,
   input  logic [N_SLAVES*DATA_W-1:0] slv_rdata,
   output logic [N_SLAVES-1:0]        slv_cs_r,
   output logic [N_SLAVES-1:0]        slv_cs_w
);
   localparam int IDX_W = idx_w(N_SLAVES);
   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_dir;
   logic [IDX_W-1:0]    r_idx;
   logic                r_ready, r_err;
   logic [N_SLAVES-1:0] r_cs_r, r_cs_w;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata, r_rdata;
   logic                w_hit, w_valid;
   logic [IDX_W-1:0]    w_idx;
   logic [CNT_W-1:0]    w_wait;
   logic [N_SLAVES-1:0] w_onehot;
   logic [DATA_W-1:0]   w_slv_rd;
   bus_region_match #(
      .ADDR_W(ADDR_W), .N_SLAVES(N_SLAVES), .IDX_W(IDX_W),
      .REGION_BASE(REGION_BASE), .REGION_MASK(REGION_MASK)
   ) u_match (
      .i_addr(cpu_address), .o_hit(w_hit), .o_idx(w_idx)
   );
   assign w_valid  = cpu_read ^ cpu_write;
   assign w_wait   = REGION_WAIT[w_idx*CNT_W +: CNT_W];
   assign w_onehot = N_SLAVES'(1) << w_idx;
   assign w_slv_rd = slv_rdata[r_idx*DATA_W +: DATA_W];
   // strobes are registered on ACCESS entry so they cover exactly the ACCESS cycles
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
         r_idx   <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_cs_r  <= '0;
         r_cs_w  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            IDLE:
               if (w_valid && w_hit) begin
                  r_state <= ACCESS;
                  r_addr  <= cpu_address;
                  r_wdata <= cpu_wdata;
                  r_dir   <= cpu_write;
                  r_idx   <= w_idx;
                  r_cnt   <= w_wait;
                  r_cs_r  <= cpu_write ? '0 : w_onehot;
                  r_cs_w  <= cpu_write ? w_onehot : '0;
               end else if (cpu_read || cpu_write) begin
                  r_state <= ERR;
                  r_ready <= 1'b1;
                  r_err   <= 1'b1;
                  r_rdata <= {DATA_W{ERR_FILL}};
               end
            ACCESS:
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               else begin
                  r_state <= DONE;
                  r_ready <= 1'b1;
                  r_cs_r  <= '0;
                  r_cs_w  <= '0;
                  if (!r_dir) r_rdata <= w_slv_rd;
               end
            default: r_state <= IDLE;
         endcase
      end
   assign cpu_rdata   = r_rdata;
   assign cpu_ready   = r_ready;
   assign bus_error   = r_err;
   assign slv_address = r_addr;
   assign slv_wdata   = r_wdata;
   assign slv_cs_r    = r_cs_r;
   assign slv_cs_w    = r_cs_w;
endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: three bus_ctrl configurations driven in lockstep against a cycle-count reference model
module tb_bus_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_address;
   logic        cpu_read, cpu_write;
   logic [7:0]  cpu_wdata;
   logic [15:0] slv_rdata;
   logic [7:0]  rdata_o [3];
   logic        ready_o [3];
   logic        berr_o  [3];
   logic [15:0] saddr_o [3];
   logic [7:0]  swd_o   [3];
   logic [1:0]  csr_o   [3];
   logic [1:0]  csw_o   [3];
   int vectors = 0, miscompares = 0;
   // region tables per instance: a = default map, b = waits 5/3, c = fully overlapping
   int base [3][2] = '{'{0, 'hF800}, '{0, 'hF800}, '{0, 0}};
   int mask [3][2] = '{'{'h8000, 'hF800}, '{'h8000, 'hF800}, '{0, 0}};
   int wt   [3][2] = '{'{0, 0}, '{5, 3}, '{0, 0}};
   logic [7:0]  exp_rd [3];
   logic [15:0] exp_sa [3];
   logic [7:0]  exp_sw [3];
   always #5 clk = ~clk;
   bus_ctrl u_a (
      .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_read(cpu_read),
      .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_o[0]),
      .cpu_ready(ready_o[0]), .bus_error(berr_o[0]), .slv_address(saddr_o[0]),
      .slv_wdata(swd_o[0]), .slv_rdata(slv_rdata), .slv_cs_r(csr_o[0]), .slv_cs_w(csw_o[0])
   );
   bus_ctrl #(.REGION_WAIT(8'h35)) u_b (
      .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_read(cpu_read),
      .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_o[1]),
      .cpu_ready(ready_o[1]), .bus_error(berr_o[1]), .slv_address(saddr_o[1]),
      .slv_wdata(swd_o[1]), .slv_rdata(slv_rdata), .slv_cs_r(csr_o[1]), .slv_cs_w(csw_o[1])
   );
   bus_ctrl #(.REGION_BASE(32'h0), .REGION_MASK(32'h0)) u_c (
      .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_read(cpu_read),
      .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_rdata(rdata_o[2]),
      .cpu_ready(ready_o[2]), .bus_error(berr_o[2]), .slv_address(saddr_o[2]),
      .slv_wdata(swd_o[2]), .slv_rdata(slv_rdata), .slv_cs_r(csr_o[2]), .slv_cs_w(csw_o[2])
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic clear_model();
      for (int i = 0; i < 3; i++) begin
         exp_rd[i] = '0;
         exp_sa[i] = '0;
         exp_sw[i] = '0;
      end
   endtask
   task automatic chk_quiet(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s rdy i%0d", tag, i), ready_o[i], 1'b0);
         chk($sformatf("%s err i%0d", tag, i), berr_o[i], 1'b0);
         chk($sformatf("%s csr i%0d", tag, i), csr_o[i], 2'b00);
         chk($sformatf("%s csw i%0d", tag, i), csw_o[i], 2'b00);
         chk($sformatf("%s rdata i%0d", tag, i), rdata_o[i], exp_rd[i]);
         chk($sformatf("%s saddr i%0d", tag, i), saddr_o[i], exp_sa[i]);
         chk($sformatf("%s swd i%0d", tag, i), swd_o[i], exp_sw[i]);
      end
   endtask
   // one request, held for a single cycle, then every instance is followed until all are idle
   task automatic xact(input logic [15:0] a, input logic rd, input logic wr,
                       input logic [7:0] wd, input logic [15:0] sr);
      int k [3];
      int n [3];
      int w [3];
      bit e [3];
      int mx;
      logic [1:0] strobe;
      mx = 0;
      for (int i = 0; i < 3; i++) begin
         k[i] = -1;
         for (int j = 0; j < 2; j++)
            if (k[i] < 0 && (int'(a) & mask[i][j]) == base[i][j]) k[i] = j;
         e[i] = (rd == wr) || k[i] < 0;
         w[i] = e[i] ? 0 : wt[i][k[i]];
         n[i] = e[i] ? 1 : w[i] + 2;
         if (n[i] > mx) mx = n[i];
      end
      cpu_address = a;
      cpu_read    = rd;
      cpu_write   = wr;
      cpu_wdata   = wd;
      slv_rdata   = sr;
      for (int c = 1; c <= mx + 1; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
         end
         for (int i = 0; i < 3; i++) begin
            strobe = (!e[i] && c <= w[i] + 1) ? 2'(1 << k[i]) : 2'b00;
            chk($sformatf("%04h rdy i%0d c%0d", a, i, c), ready_o[i], c == n[i]);
            chk($sformatf("%04h err i%0d c%0d", a, i, c), berr_o[i], c == n[i] && e[i]);
            chk($sformatf("%04h csr i%0d c%0d", a, i, c), csr_o[i], rd ? strobe : 2'b00);
            chk($sformatf("%04h csw i%0d c%0d", a, i, c), csw_o[i], wr ? strobe : 2'b00);
            if (c == 1 && !e[i]) begin
               exp_sa[i] = a;
               exp_sw[i] = wd;
            end
            if (c == n[i]) begin
               exp_rd[i] = e[i] ? 8'hFF : (rd ? sr[k[i]*8 +: 8] : exp_rd[i]);
               chk($sformatf("%04h rdata i%0d", a, i), rdata_o[i], exp_rd[i]);
            end
            chk($sformatf("%04h saddr i%0d c%0d", a, i, c), saddr_o[i], exp_sa[i]);
            chk($sformatf("%04h swd i%0d c%0d", a, i, c), swd_o[i], exp_sw[i]);
         end
      end
   endtask
   initial begin
      logic [15:0] a;
      int op, sel;
      cpu_address = '0;
      cpu_read    = 1'b0;
      cpu_write   = 1'b0;
      cpu_wdata   = '0;
      slv_rdata   = '0;
      reset       = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      chk_quiet("reset");
      reset = 1'b1;
      @(posedge clk);
      #1;
      xact(16'h1234, 1'b1, 1'b0, 8'h00, 16'h00A5);
      xact(16'hF810, 1'b0, 1'b1, 8'h5C, 16'h0000);
      xact(16'h9000, 1'b1, 1'b0, 8'h00, 16'h3C3C);
      xact(16'h0000, 1'b1, 1'b1, 8'h77, 16'h1111);
      xact(16'h0100, 1'b1, 0, 8'h00, 16'h5AC3);
      xact(16'hFFFF, 1'b0, 1'b1, 8'hE1, 16'h0F0F);
      // abort a long access on instance b with an asynchronous reset
      cpu_address = 16'h0040;
      cpu_read    = 1'b1;
      slv_rdata   = 16'hBEEF;
      @(posedge clk);
      #1;
      cpu_read = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("abort pre csr", csr_o[1], 2'b01);
      chk("abort pre rdy", ready_o[1], 1'b0);
      reset = 1'b0;
      #1;
      clear_model();
      chk_quiet("abort");
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("abort hold rdy", ready_o[1], 1'b0);
         chk("abort hold csr", csr_o[1], 2'b00);
      end
      reset = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      chk_quiet("post abort");
      for (int t = 0; t < 40; t++) begin
         a   = 16'($urandom);
         sel = $urandom_range(0, 2);
         op  = $urandom_range(0, 4);
         a   = sel == 1 ? (a & 16'h7FFF) : sel == 2 ? (a | 16'hF800) : a;
         xact(a, op < 2 || op == 4, op >= 2, 8'($urandom), 16'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
